// File: rtl/seg_scan_driver_pkg.sv
// Shared constants for the seven-segment scan driver: glyph patterns {a..g},
// the blank bus value and the slot-index width.
`timescale 1ns/1ps
package seg_scan_driver_pkg;
  localparam int SLOT_W = 2;
  localparam logic [7:0] SEG_BLANK = 8'h00;

  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;
  localparam logic [6:0] SEG_A = 7'b1110111;
  localparam logic [6:0] SEG_B = 7'b0011111;
  localparam logic [6:0] SEG_C = 7'b1001110;
  localparam logic [6:0] SEG_D = 7'b0111101;
  localparam logic [6:0] SEG_E = 7'b1001111;
  localparam logic [6:0] SEG_F = 7'b1000111;
endpackage

// File: rtl/seg_scan_driver_seg7_decode.sv
// Combinational hex-to-seven-segment decoder; output bus is {a,b,c,d,e,f,g,dp}.
`timescale 1ns/1ps
module seg7_decode
  import seg_scan_driver_pkg::*;
(
  input  logic [3:0] i_hex,
  input  logic       i_dp,
  output logic [7:0] o_seg
);
  logic [6:0] w_glyph;

  always_comb begin
    w_glyph = SEG_0;
    case (i_hex)
      4'h0: w_glyph = SEG_0;
      4'h1: w_glyph = SEG_1;
      4'h2: w_glyph = SEG_2;
      4'h3: w_glyph = SEG_3;
      4'h4: w_glyph = SEG_4;
      4'h5: w_glyph = SEG_5;
      4'h6: w_glyph = SEG_6;
      4'h7: w_glyph = SEG_7;
      4'h8: w_glyph = SEG_8;
      4'h9: w_glyph = SEG_9;
      4'hA: w_glyph = SEG_A;
      4'hB: w_glyph = SEG_B;
      4'hC: w_glyph = SEG_C;
      4'hD: w_glyph = SEG_D;
      4'hE: w_glyph = SEG_E;
      4'hF: w_glyph = SEG_F;
      default: w_glyph = SEG_0;
    endcase
  end

  assign o_seg = {w_glyph, i_dp};
endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 8-digit seven-segment driver: two 4-digit groups scanned in
// parallel, one digit per group per slot, with a trailing blank gap in each slot.
`timescale 1ns/1ps
module seg_scan_driver
  import seg_scan_driver_pkg::*;
#(
  parameter int SCAN_DIV     = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [31:0] digit_data,
  input  logic [7:0]  digit_en,
  input  logic [7:0]  dp_en,
  output logic [7:0]  tub_segments1,
  output logic [7:0]  tub_segments2,
  output logic [7:0]  tub_select,
  output logic        frame_tick
);
  localparam int          CNT_W      = $clog2(SCAN_DIV);
  localparam logic [31:0] LAST_CNT   = 32'(SCAN_DIV - 1);
  localparam logic [31:0] ACTIVE_LEN = 32'(SCAN_DIV - BLANK_CYCLES);

  logic [CNT_W-1:0]  r_slot_cnt;
  logic [SLOT_W-1:0] r_slot_idx;
  logic [3:0]        r_hex_a, r_hex_b;
  logic              r_en_a, r_en_b, r_dp_a, r_dp_b;

  logic [31:0] w_cnt32;
  logic        w_slot_start, w_slot_last, w_active, w_frame_wrap;
  logic [3:0]  w_hex_a, w_hex_b;
  logic        w_en_a, w_en_b, w_dp_a, w_dp_b;
  logic [3:0]  w_onehot;
  logic [7:0]  w_sel, w_seg_a, w_seg_b;

  assign w_cnt32      = 32'(r_slot_cnt);
  assign w_slot_start = (w_cnt32 == 32'd0);
  assign w_slot_last  = (w_cnt32 == LAST_CNT);
  assign w_active     = (w_cnt32 < ACTIVE_LEN);
  assign w_frame_wrap = w_slot_last && (r_slot_idx == '1);

  // On the first cycle of a slot the live inputs are used directly so the
  // slot's first lit cycle already shows the freshly latched digits.
  assign w_hex_a = w_slot_start ? digit_data[{r_slot_idx, 2'b00} +: 4]       : r_hex_a;
  assign w_hex_b = w_slot_start ? digit_data[{1'b1, r_slot_idx, 2'b00} +: 4] : r_hex_b;
  assign w_en_a  = w_slot_start ? digit_en[{1'b0, r_slot_idx}]               : r_en_a;
  assign w_en_b  = w_slot_start ? digit_en[{1'b1, r_slot_idx}]               : r_en_b;
  assign w_dp_a  = w_slot_start ? dp_en[{1'b0, r_slot_idx}]                  : r_dp_a;
  assign w_dp_b  = w_slot_start ? dp_en[{1'b1, r_slot_idx}]                  : r_dp_b;

  // Digit k is wired to select bit 7-k, so slot idx lights bits 7-idx and 3-idx.
  assign w_onehot = 4'b1000 >> r_slot_idx;
  assign w_sel    = {(w_en_a ? w_onehot : 4'b0000), (w_en_b ? w_onehot : 4'b0000)};

  seg7_decode u_dec_a (
    .i_hex (w_hex_a),
    .i_dp  (w_dp_a),
    .o_seg (w_seg_a)
  );

  seg7_decode u_dec_b (
    .i_hex (w_hex_b),
    .i_dp  (w_dp_b),
    .o_seg (w_seg_b)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_slot_cnt    <= '0;
      r_slot_idx    <= '0;
      r_hex_a       <= '0;
      r_hex_b       <= '0;
      r_en_a        <= 1'b0;
      r_en_b        <= 1'b0;
      r_dp_a        <= 1'b0;
      r_dp_b        <= 1'b0;
      tub_segments1 <= SEG_BLANK;
      tub_segments2 <= SEG_BLANK;
      tub_select    <= '0;
      frame_tick    <= 1'b0;
    end else if (!enable) begin
      r_slot_cnt    <= '0;
      r_slot_idx    <= '0;
      tub_segments1 <= SEG_BLANK;
      tub_segments2 <= SEG_BLANK;
      tub_select    <= '0;
      frame_tick    <= 1'b0;
    end else begin
      if (w_slot_start) begin
        r_hex_a <= w_hex_a;
        r_hex_b <= w_hex_b;
        r_en_a  <= w_en_a;
        r_en_b  <= w_en_b;
        r_dp_a  <= w_dp_a;
        r_dp_b  <= w_dp_b;
      end
      if (w_slot_last) begin
        r_slot_cnt <= '0;
        r_slot_idx <= r_slot_idx + 1'b1;
      end else begin
        r_slot_cnt <= r_slot_cnt + 1'b1;
      end
      frame_tick    <= w_frame_wrap;
      tub_select    <= w_active ? w_sel : 8'h00;
      tub_segments1 <= (w_active && w_en_a) ? w_seg_a : SEG_BLANK;
      tub_segments2 <= (w_active && w_en_b) ? w_seg_b : SEG_BLANK;
    end
  end
endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: vector table, hand-written corner
// sequences and a randomized run against a slot-arithmetic reference model.
`timescale 1ns/1ps
module tb_seg_scan_driver;
  localparam int SCAN_DIV     = 8;
  localparam int BLANK_CYCLES = 2;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [31:0] digit_data;
  logic [7:0]  digit_en;
  logic [7:0]  dp_en;
  logic [7:0]  tub_segments1;
  logic [7:0]  tub_segments2;
  logic [7:0]  tub_select;
  logic        frame_tick;

  seg_scan_driver #(
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .digit_data    (digit_data),
    .digit_en      (digit_en),
    .dp_en         (dp_en),
    .tub_segments1 (tub_segments1),
    .tub_segments2 (tub_segments2),
    .tub_select    (tub_select),
    .frame_tick    (frame_tick)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // scoreboard: packed {sel, seg1, seg2, frame_tick}
  logic [24:0] exp_q[$];

  logic [6:0] seg_tab [16];

  // reference model state: cycles since scanning (re)started, plus the
  // digits captured at the start of the current slot
  int         m_k;
  logic [3:0] m_hex_a, m_hex_b;
  logic       m_en_a, m_en_b, m_dp_a, m_dp_b;

  typedef struct {
    logic [31:0] data;
    logic [7:0]  en;
    logic [7:0]  dp;
    logic [7:0]  s1;
    logic [7:0]  s2;
    logic [7:0]  sel;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [24:0] model_edge();
    logic [7:0] sel, s1, s2;
    logic       ft;
    int         cnt, slot;
    sel = '0; s1 = '0; s2 = '0; ft = 1'b0;
    if (!reset || !enable) begin
      m_k = 0;
    end else begin
      cnt  = m_k % SCAN_DIV;
      slot = (m_k / SCAN_DIV) % 4;
      if (cnt == 0) begin
        m_hex_a = digit_data[4*slot +: 4];
        m_hex_b = digit_data[4*(slot+4) +: 4];
        m_en_a  = digit_en[slot];
        m_en_b  = digit_en[slot+4];
        m_dp_a  = dp_en[slot];
        m_dp_b  = dp_en[slot+4];
      end
      if (cnt < SCAN_DIV - BLANK_CYCLES) begin
        sel[7-slot] = m_en_a;
        sel[3-slot] = m_en_b;
        if (m_en_a) s1 = {seg_tab[m_hex_a], m_dp_a};
        if (m_en_b) s2 = {seg_tab[m_hex_b], m_dp_b};
      end
      ft = ((m_k % (4*SCAN_DIV)) == (4*SCAN_DIV - 1));
      m_k++;
    end
    return {sel, s1, s2, ft};
  endfunction

  // driver: one clock, inputs stable across the edge, compared on the falling edge
  task automatic tick();
    logic [24:0] e;
    exp_q.push_back(model_edge());
    @(posedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    check("model_sel",  {24'h0, tub_select},    {24'h0, e[24:17]});
    check("model_seg1", {24'h0, tub_segments1}, {24'h0, e[16:9]});
    check("model_seg2", {24'h0, tub_segments2}, {24'h0, e[8:1]});
    check("model_tick", {31'h0, frame_tick},    {31'h0, e[0]});
  endtask

  task automatic restart();
    enable = 1'b0;
    tick();
    enable = 1'b1;
  endtask

  task automatic set_inputs(input logic [31:0] d, input logic [7:0] en, input logic [7:0] dp);
    digit_data = d;
    digit_en   = en;
    dp_en      = dp;
  endtask

  logic [7:0] sel_exp [4];
  int         ft_count, ft_bad, dp_hits, a_hits;

  initial begin
    seg_tab = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
    // slot-0 expectations for digits 0 and 4, worked out by hand from the glyph table
    vecs[0] = '{32'h9AB5_C3E0, 8'hFF, 8'h00, 8'hFC, 8'hB6, 8'h88};
    vecs[1] = '{32'h000F_0008, 8'hFF, 8'h11, 8'hFF, 8'h8F, 8'h88};
    vecs[2] = '{32'h000B_000A, 8'h01, 8'h10, 8'hEE, 8'h00, 8'h80};
    vecs[3] = '{32'h000D_0003, 8'hF0, 8'h01, 8'h00, 8'h7A, 8'h08};
    vecs[4] = '{32'h0009_0002, 8'h11, 8'hFF, 8'hDB, 8'hF7, 8'h88};
    vecs[5] = '{32'h0004_0001, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00};
    sel_exp = '{8'h88, 8'h44, 8'h22, 8'h11};
    m_k = 0;

    reset  = 1'b1;
    enable = 1'b0;
    set_inputs(32'h0, 8'h00, 8'h00);
    #2 reset = 1'b0;
    #1;
    check("reset_sel",  {24'h0, tub_select},    32'h0);
    check("reset_seg1", {24'h0, tub_segments1}, 32'h0);
    check("reset_seg2", {24'h0, tub_segments2}, 32'h0);
    check("reset_tick", {31'h0, frame_tick},    32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    // table-driven slot-0 vectors
    for (int i = 0; i < 6; i++) begin
      restart();
      set_inputs(vecs[i].data, vecs[i].en, vecs[i].dp);
      tick();
      check($sformatf("vec%0d_sel", i),  {24'h0, tub_select},    {24'h0, vecs[i].sel});
      check($sformatf("vec%0d_seg1", i), {24'h0, tub_segments1}, {24'h0, vecs[i].s1});
      check($sformatf("vec%0d_seg2", i), {24'h0, tub_segments2}, {24'h0, vecs[i].s2});
    end

    // active window of 6 lit cycles then 2 dark cycles
    restart();
    set_inputs(32'h9AB5_C3E0, 8'hFF, 8'h00);
    for (int t = 0; t < SCAN_DIV; t++) begin
      tick();
      check($sformatf("window_sel_c%0d", t), {24'h0, tub_select},
            (t < SCAN_DIV - BLANK_CYCLES) ? 32'h88 : 32'h0);
    end

    // asynchronous reset in the middle of a lit window
    restart();
    set_inputs(32'h8888_8888, 8'hFF, 8'h00);
    for (int t = 0; t < 3; t++) tick();
    #2 reset = 1'b0;
    #1;
    check("midreset_sel",  {24'h0, tub_select},    32'h0);
    check("midreset_seg1", {24'h0, tub_segments1}, 32'h0);
    check("midreset_seg2", {24'h0, tub_segments2}, 32'h0);
    @(negedge clk);
    tick();
    reset = 1'b1;
    tick();
    check("after_reset_sel", {24'h0, tub_select}, 32'h88);

    // slot order and frame_tick spacing
    restart();
    set_inputs(32'h7654_3210, 8'hFF, 8'h00);
    ft_count = 0;
    ft_bad   = 0;
    for (int t = 1; t <= 96; t++) begin
      tick();
      if (frame_tick) begin
        ft_count++;
        if (t % 32 != 0) ft_bad++;
      end
      if (t % 8 == 1)
        check($sformatf("order_sel_t%0d", t), {24'h0, tub_select}, {24'h0, sel_exp[(t/8)%4]});
    end
    check("frame_tick_count", ft_count, 3);
    check("frame_tick_misplaced", ft_bad, 0);

    // only group B enabled, decimal point on digit 7
    restart();
    set_inputs($urandom, 8'hF0, 8'h80);
    dp_hits = 0;
    a_hits  = 0;
    for (int t = 0; t < 32; t++) begin
      tick();
      if (tub_select[7:4] != 4'h0 || tub_segments1 != 8'h00) a_hits++;
      if (tub_segments2[0]) begin
        dp_hits++;
        check("dp_only_digit7", {24'h0, tub_select}, 32'h01);
      end
    end
    check("group_a_dark", a_hits, 0);
    check("dp_cycles", dp_hits, SCAN_DIV - BLANK_CYCLES);

    // mid-slot data change is held off until the next slot
    restart();
    set_inputs(32'h1111_1111, 8'hFF, 8'h00);
    for (int t = 0; t < 3; t++) tick();
    digit_data = 32'h8888_8888;
    for (int t = 3; t < SCAN_DIV - BLANK_CYCLES; t++) begin
      tick();
      check($sformatf("held_seg1_c%0d", t), {24'h0, tub_segments1}, 32'h60);
    end
    for (int t = 0; t < BLANK_CYCLES; t++) tick();
    tick();
    check("new_slot_seg1", {24'h0, tub_segments1}, 32'hFE);
    check("new_slot_sel",  {24'h0, tub_select},    32'h44);

    // enable dropped at cnt 4 of slot 2, then restored
    restart();
    set_inputs(32'h8888_8888, 8'hFF, 8'h00);
    for (int t = 0; t < 2*SCAN_DIV + 4; t++) tick();
    enable = 1'b0;
    tick();
    check("dark_sel",  {24'h0, tub_select},    32'h0);
    check("dark_seg1", {24'h0, tub_segments1}, 32'h0);
    check("dark_seg2", {24'h0, tub_segments2}, 32'h0);
    for (int t = 0; t < 3; t++) begin
      tick();
      check("dark_tick", {31'h0, frame_tick}, 32'h0);
    end
    enable = 1'b1;
    tick();
    check("reenable_sel", {24'h0, tub_select}, 32'h88);

    // randomized run against the model
    for (int t = 0; t < 800; t++) begin
      if ($urandom_range(0, 5) == 0) digit_data = $urandom;
      if ($urandom_range(0, 19) == 0) begin
        digit_en = 8'($urandom);
        dp_en    = 8'($urandom);
      end
      enable = ($urandom_range(0, 49) != 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
